// File: rtl/seg7_mux_driver_pkg.sv
// Shared widths and glyph tables for the multiplexed 7-segment driver.
// Glyph bit order is seg[0]=a ... seg[6]=g.
package seg7_mux_driver_pkg;

  localparam int unsigned SEG_W = 7;
  localparam int unsigned NIB_W = 4;

  localparam logic [SEG_W-1:0] BLANK = 7'h00;

  // Glyphs shared by both modes
  localparam logic [SEG_W-1:0] GLYPH_0 = 7'h3F;
  localparam logic [SEG_W-1:0] GLYPH_1 = 7'h06;
  localparam logic [SEG_W-1:0] GLYPH_2 = 7'h5B;
  localparam logic [SEG_W-1:0] GLYPH_3 = 7'h4F;
  localparam logic [SEG_W-1:0] GLYPH_4 = 7'h66;
  localparam logic [SEG_W-1:0] GLYPH_5 = 7'h6D;
  localparam logic [SEG_W-1:0] GLYPH_7 = 7'h07;
  localparam logic [SEG_W-1:0] GLYPH_8 = 7'h7F;

  // LS49-compatible shapes (6 and 9 without tails, odd symbols for 10-15)
  localparam logic [SEG_W-1:0] LS49_6 = 7'h7C;
  localparam logic [SEG_W-1:0] LS49_9 = 7'h67;
  localparam logic [SEG_W-1:0] LS49_A = 7'h58;
  localparam logic [SEG_W-1:0] LS49_B = 7'h4C;
  localparam logic [SEG_W-1:0] LS49_C = 7'h62;
  localparam logic [SEG_W-1:0] LS49_D = 7'h69;
  localparam logic [SEG_W-1:0] LS49_E = 7'h78;
  localparam logic [SEG_W-1:0] LS49_F = BLANK;

  // Hexadecimal shapes
  localparam logic [SEG_W-1:0] HEX_6 = 7'h7D;
  localparam logic [SEG_W-1:0] HEX_9 = 7'h6F;
  localparam logic [SEG_W-1:0] HEX_A = 7'h77;
  localparam logic [SEG_W-1:0] HEX_B = 7'h7C;
  localparam logic [SEG_W-1:0] HEX_C = 7'h39;
  localparam logic [SEG_W-1:0] HEX_D = 7'h5E;
  localparam logic [SEG_W-1:0] HEX_E = 7'h79;
  localparam logic [SEG_W-1:0] HEX_F = 7'h71;

  // Active-high segment pattern for one nibble
  function automatic logic [SEG_W-1:0] seg7_glyph(input logic [NIB_W-1:0] code,
                                                   input logic            hex);
    logic [SEG_W-1:0] g;
    g = BLANK;
    case (code)
      4'h0:    g = GLYPH_0;
      4'h1:    g = GLYPH_1;
      4'h2:    g = GLYPH_2;
      4'h3:    g = GLYPH_3;
      4'h4:    g = GLYPH_4;
      4'h5:    g = GLYPH_5;
      4'h6:    g = hex ? HEX_6 : LS49_6;
      4'h7:    g = GLYPH_7;
      4'h8:    g = GLYPH_8;
      4'h9:    g = hex ? HEX_9 : LS49_9;
      4'hA:    g = hex ? HEX_A : LS49_A;
      4'hB:    g = hex ? HEX_B : LS49_B;
      4'hC:    g = hex ? HEX_C : LS49_C;
      4'hD:    g = hex ? HEX_D : LS49_D;
      4'hE:    g = hex ? HEX_E : LS49_E;
      default: g = hex ? HEX_F : LS49_F;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg7_mux_driver_if.sv
// User-side and pin-side signals of the 7-segment driver.
// slave = the driver, master = the logic that feeds it and watches the pins.
interface seg7_mux_driver_if
  import seg7_mux_driver_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned PWM_BITS = 4
);

  logic [NIB_W*DIGITS-1:0] value;
  logic                    load;
  logic [DIGITS-1:0]       dp_in;
  logic                    bi_n;
  logic                    lz_suppress;
  logic [PWM_BITS-1:0]     brightness;
  logic [SEG_W-1:0]        seg;
  logic                    dp;
  logic [DIGITS-1:0]       digit_en;
  logic                    frame_tick;

  modport master (
    output value, load, dp_in, bi_n, lz_suppress, brightness,
    input  seg, dp, digit_en, frame_tick
  );

  modport slave (
    input  value, load, dp_in, bi_n, lz_suppress, brightness,
    output seg, dp, digit_en, frame_tick
  );

endinterface

// File: rtl/seg7_mux_driver_decode.sv
// Combinational nibble-to-segment decoder; HEX_MODE selects hex or LS49 shapes
// for the codes where the two families differ.
module seg7_decode
  import seg7_mux_driver_pkg::*;
#(
  parameter int unsigned HEX_MODE = 0
) (
  input  logic [NIB_W-1:0] code_i,
  output logic [SEG_W-1:0] glyph_o_c
);

  localparam logic USE_HEX = (HEX_MODE != 0);

  assign glyph_o_c = seg7_glyph(code_i, USE_HEX);

endmodule

// File: rtl/seg7_mux_driver.sv
// Multiplexed DIGITS-wide 7-segment driver: time-slot scan, PWM dimming,
// leading-zero blanking and frame-synchronous display update.
module seg7_mux_driver
  import seg7_mux_driver_pkg::*;
#(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned SCAN_BITS   = 16,
  parameter int unsigned PWM_BITS    = 4,
  parameter int unsigned HEX_MODE    = 0,
  parameter int unsigned SEG_ACT_LOW = 0,
  parameter int unsigned DIG_ACT_LOW = 1
) (
  input  logic             clk,
  input  logic             rst,
  seg7_mux_driver_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(DIGITS);
  localparam int unsigned VAL_W = NIB_W * DIGITS;

  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [SEG_W-1:0]  SEG_OFF  = (SEG_ACT_LOW != 0) ? ~BLANK : BLANK;
  localparam logic              DP_OFF   = (SEG_ACT_LOW != 0);
  localparam logic [DIGITS-1:0] DIG_OFF  = (DIG_ACT_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [SCAN_BITS-1:0] presc_q, presc_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [VAL_W-1:0]     shadow_val_q, shadow_val_d;
  logic [DIGITS-1:0]    shadow_dp_q, shadow_dp_d;
  logic [VAL_W-1:0]     disp_val_q, disp_val_d;
  logic [DIGITS-1:0]    disp_dp_q, disp_dp_d;
  logic [SEG_W-1:0]     seg_q, seg_d;
  logic                 dp_q, dp_d;
  logic [DIGITS-1:0]    dig_q, dig_d;
  logic                 ftick_q, ftick_d;

  logic                 tick_c;
  logic                 wrap_c;
  logic                 zero_run_c;
  logic [DIGITS-1:0]    lz_mask_c;
  logic [DIGITS-1:0]    slot_c;
  logic [NIB_W-1:0]     nib_c;
  logic                 dp_bit_c;
  logic                 blank_c;
  logic [PWM_BITS-1:0]  duty_pos_c;
  logic                 lit_c;
  logic [SEG_W-1:0]     glyph_c;

  // Scan counters; the shadow already folds in a same-cycle load, so a load
  // coinciding with the frame wrap reaches the display directly.
  always_comb begin
    tick_c       = (presc_q == '1);
    wrap_c       = tick_c && (idx_q == IDX_LAST);
    presc_d      = presc_q + SCAN_BITS'(1);
    idx_d        = idx_q;
    shadow_val_d = shadow_val_q;
    shadow_dp_d  = shadow_dp_q;
    disp_val_d   = disp_val_q;
    disp_dp_d    = disp_dp_q;
    ftick_d      = wrap_c;
    if (tick_c) begin
      idx_d = wrap_c ? '0 : idx_q + IDX_W'(1);
    end
    if (bus.load) begin
      shadow_val_d = bus.value;
      shadow_dp_d  = bus.dp_in;
    end
    if (wrap_c) begin
      disp_val_d = shadow_val_d;
      disp_dp_d  = shadow_dp_d;
    end
  end

  // A digit is a leading zero when it and everything above it is 0 with no dp.
  always_comb begin
    zero_run_c = 1'b1;
    lz_mask_c  = '0;
    slot_c     = '0;
    nib_c      = '0;
    dp_bit_c   = 1'b0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_run_c   = zero_run_c && (disp_val_q[NIB_W*k +: NIB_W] == '0) && !disp_dp_q[k];
      lz_mask_c[k] = zero_run_c && (k != 0);
    end
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        slot_c[k] = 1'b1;
        nib_c     = disp_val_q[NIB_W*k +: NIB_W];
        dp_bit_c  = disp_dp_q[k];
      end
    end
    blank_c    = bus.lz_suppress && |(lz_mask_c & slot_c);
    duty_pos_c = presc_q[SCAN_BITS-1 -: PWM_BITS];
    lit_c      = bus.bi_n && (duty_pos_c < bus.brightness);
  end

  seg7_decode #(
    .HEX_MODE (HEX_MODE)
  ) u_decode (
    .code_i    (nib_c),
    .glyph_o_c (glyph_c)
  );

  // Pin polarity applied before the output registers
  always_comb begin
    seg_d = ((lit_c && !blank_c) ? glyph_c : BLANK) ^ SEG_OFF;
    dp_d  = (lit_c && !blank_c && dp_bit_c) ^ DP_OFF;
    dig_d = (lit_c ? slot_c : '0) ^ DIG_OFF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q      <= '0;
      idx_q        <= '0;
      shadow_val_q <= '0;
      shadow_dp_q  <= '0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      seg_q        <= SEG_OFF;
      dp_q         <= DP_OFF;
      dig_q        <= DIG_OFF;
      ftick_q      <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      shadow_val_q <= shadow_val_d;
      shadow_dp_q  <= shadow_dp_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      dig_q        <= dig_d;
      ftick_q      <= ftick_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.digit_en   = dig_q;
  assign bus.frame_tick = ftick_q;

endmodule
